// File: rtl/demux_pkg.sv
// Shared definitions for the 1x2 demux dispatch front-end:
// default widths and channel index constants.
package demux_pkg;

    // Default data word width in bits.
    localparam int unsigned DW_DEFAULT = 8;

    // Default width of each per-channel dispatch counter.
    localparam int unsigned CW_DEFAULT = 16;

    // Channel index constants (the demux select value for each output).
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage : demux_pkg

// File: rtl/demux_out_slot.sv
// One-entry output holding register with valid/ready handshake.
// A word is loaded when load_i is high; the slot empties when the consumer
// takes the word and nothing new is loaded in the same cycle. can_load_o
// reports whether a load this cycle is legal (empty, or draining now).
module demux_out_slot #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          can_load_o
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // Next-state for the slot: load wins over drain so a same-cycle
    // drain and load keeps the slot full with the new word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            // Data is left as-is; it is a don't-care once valid drops.
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot state register; reset discards any held word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {DW{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // The slot can take a word when empty, or when its current word
    // leaves this cycle. ready_i on an empty slot has no other effect.
    always_comb begin
        can_load_o = (!valid_q) || ready_i;
    end

    // Drive the registered slot contents out.
    always_comb begin
        valid_o = valid_q;
        data_o  = data_q;
    end

endmodule : demux_out_slot

// File: rtl/demux_1x2_dispatch.sv
// Registered dispatch front-end for the 1x2 demux stage.
// Accepts a valid/ready stream and steers each word into one of two
// one-entry output slots, either by strict round-robin or by a forced
// select (force_en/force_sel mirror the demux en/s inputs).
// Per-channel counters record how many words went to each channel.
//
// Optional build macro: DEMUX_DISPATCH_SKIP_EN
//   When defined, round-robin mode skips a blocked slot and routes to
//   the other channel if that one can load; the pointer then points
//   back at the skipped channel. When undefined, alternation is strict.
module demux_1x2_dispatch
    import demux_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          force_en,
    input  logic          force_sel,
    output logic [1:0]    out_valid,
    input  logic [1:0]    out_ready,
    output logic [DW-1:0] out_data0,
    output logic [DW-1:0] out_data1,
    output logic          sel_o,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic          ptr_q;
    logic          ptr_d;
    logic [CW-1:0] cnt0_q;
    logic [CW-1:0] cnt0_d;
    logic [CW-1:0] cnt1_q;
    logic [CW-1:0] cnt1_d;

    logic [1:0]    can_load_s;
    logic [1:0]    slot_valid_s;
    logic [DW-1:0] slot0_data_s;
    logic [DW-1:0] slot1_data_s;
    logic          other_s;
    logic          rr_tgt_s;
    logic          tgt_s;
    logic          ready_s;
    logic          accept_s;
    logic          load0_s;
    logic          load1_s;

    // Round-robin candidate: the pointer, optionally skipping a blocked slot.
    always_comb begin
        other_s = ~ptr_q;
`ifdef DEMUX_DISPATCH_SKIP_EN
        if ((!can_load_s[ptr_q]) && can_load_s[other_s]) begin
            rr_tgt_s = other_s;
        end else begin
            rr_tgt_s = ptr_q;
        end
`else
        rr_tgt_s = ptr_q;
`endif
    end

    // Final target channel: forced select overrides round-robin.
    always_comb begin
        if (force_en) begin
            tgt_s = force_sel;
        end else begin
            tgt_s = rr_tgt_s;
        end
    end

    // Handshake: ready depends only on the target slot, never on in_valid.
    always_comb begin
        ready_s  = can_load_s[tgt_s];
        accept_s = in_valid && ready_s;
        load0_s  = accept_s && (tgt_s == CH0);
        load1_s  = accept_s && (tgt_s == CH1);
    end

    // Next-state for pointer and counters on an accepted word.
    always_comb begin
        ptr_d  = ptr_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept_s) begin
            // Forced accepts leave the round-robin position untouched.
            // In round-robin mode the next word goes to the channel not
            // just used, which also covers the skip case.
            if (!force_en) begin
                ptr_d = ~tgt_s;
            end else begin
                ptr_d = ptr_q;
            end
            if (tgt_s == CH0) begin
                cnt0_d = cnt0_q + CNT_ONE;
            end else begin
                cnt1_d = cnt1_q + CNT_ONE;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer and dispatch counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= CH0;
            cnt0_q <= {CW{1'b0}};
            cnt1_q <= {CW{1'b0}};
        end else begin
            ptr_q  <= ptr_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    demux_out_slot #(
        .DW (DW)
    ) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load0_s),
        .data_i     (in_data),
        .ready_i    (out_ready[0]),
        .valid_o    (slot_valid_s[0]),
        .data_o     (slot0_data_s),
        .can_load_o (can_load_s[0])
    );

    demux_out_slot #(
        .DW (DW)
    ) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load1_s),
        .data_i     (in_data),
        .ready_i    (out_ready[1]),
        .valid_o    (slot_valid_s[1]),
        .data_o     (slot1_data_s),
        .can_load_o (can_load_s[1])
    );

    // Output drive: slot contents, counters, ready and current target.
    always_comb begin
        out_valid = slot_valid_s;
        out_data0 = slot0_data_s;
        out_data1 = slot1_data_s;
        cnt0      = cnt0_q;
        cnt1      = cnt1_q;
        in_ready  = ready_s;
        sel_o     = tgt_s;
    end

endmodule : demux_1x2_dispatch

// File: tb/tb_demux_1x2_dispatch.sv
// Directed self-checking bench for demux_1x2_dispatch (DW=8, CW=4).
// Expected values are hand-computed for each step.
module tb_demux_1x2_dispatch;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          force_en;
    logic          force_sel;
    logic [1:0]    out_valid;
    logic [1:0]    out_ready;
    logic [DW-1:0] out_data0;
    logic [DW-1:0] out_data1;
    logic          sel_o;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int checks;
    int errors;

    demux_1x2_dispatch #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .sel_o     (sel_o),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        force_en  = 1'b0;
        force_sel = 1'b0;
        out_ready = 2'b00;

        // ---- reset state ----
        #2;
        chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
        chk("rst_cnt0", {28'd0, cnt0}, 32'd0);
        chk("rst_cnt1", {28'd0, cnt1}, 32'd0);
        chk("rst_sel", {31'd0, sel_o}, 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // ---- round-robin, consumers always ready ----
        out_ready = 2'b11;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        #1;
        chk("rr_ready_a", {31'd0, in_ready}, 32'd1);
        chk("rr_sel_a", {31'd0, sel_o}, 32'd0);
        tick();
        chk("rr_valid_a", {30'd0, out_valid}, 32'd1);
        chk("rr_data0_a", {24'd0, out_data0}, 32'h11);
        in_data = 8'h22;
        #1;
        chk("rr_ready_b", {31'd0, in_ready}, 32'd1);
        chk("rr_sel_b", {31'd0, sel_o}, 32'd1);
        tick();
        chk("rr_valid_b", {30'd0, out_valid}, 32'd2);
        chk("rr_data1_b", {24'd0, out_data1}, 32'h22);
        in_data = 8'h33;
        #1;
        chk("rr_sel_c", {31'd0, sel_o}, 32'd0);
        chk("rr_ready_c", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rr_valid_c", {30'd0, out_valid}, 32'd1);
        chk("rr_data0_c", {24'd0, out_data0}, 32'h33);
        in_data = 8'h44;
        #1;
        chk("rr_ready_d", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rr_valid_d", {30'd0, out_valid}, 32'd2);
        chk("rr_data1_d", {24'd0, out_data1}, 32'h44);
        chk("rr_cnt0", {28'd0, cnt0}, 32'd2);
        chk("rr_cnt1", {28'd0, cnt1}, 32'd2);
        in_valid = 1'b0;
        tick();
        chk("rr_drained", {30'd0, out_valid}, 32'd0);
        chk("rr_sel_end", {31'd0, sel_o}, 32'd0);

        // ---- backpressure ----
        out_ready = 2'b00;
        in_valid  = 1'b1;
        in_data   = 8'hA0;
        tick();
        chk("bp_valid_a", {30'd0, out_valid}, 32'd1);
        chk("bp_data0", {24'd0, out_data0}, 32'hA0);
        in_data = 8'hA1;
        #1;
        chk("bp_ready_b", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_valid_b", {30'd0, out_valid}, 32'd3);
        chk("bp_data1", {24'd0, out_data1}, 32'hA1);
        chk("bp_cnt0", {28'd0, cnt0}, 32'd3);
        chk("bp_cnt1", {28'd0, cnt1}, 32'd3);
        in_data = 8'hA2;
        #1;
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 2'b10;
        #1;
`ifdef DEMUX_DISPATCH_SKIP_EN
        chk("bp_skip_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_skip_sel", {31'd0, sel_o}, 32'd1);
`else
        chk("bp_strict_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_strict_sel", {31'd0, sel_o}, 32'd0);
`endif
        tick();
        chk("bp_drain1", {30'd0, out_valid}, 32'd1);
        out_ready = 2'b01;
        tick();
        chk("bp_drain0", {30'd0, out_valid}, 32'd0);
        chk("bp_cnt0_hold", {28'd0, cnt0}, 32'd3);

        // ---- forced routing to channel 1 ----
        force_en  = 1'b1;
        force_sel = 1'b1;
        out_ready = 2'b10;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hB0 + 8'(i);
            #1;
            chk("frc_sel", {31'd0, sel_o}, 32'd1);
            chk("frc_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("frc_valid", {30'd0, out_valid}, 32'd2);
            chk("frc_data1", {24'd0, out_data1}, 32'hB0 + 32'(i));
        end
        chk("frc_cnt1", {28'd0, cnt1}, 32'd7);
        chk("frc_cnt0", {28'd0, cnt0}, 32'd3);
        in_valid = 1'b0;
        force_en = 1'b0;
        #1;
        chk("frc_ptr_kept", {31'd0, sel_o}, 32'd0);
        tick();
        chk("frc_drained", {30'd0, out_valid}, 32'd0);

        // ---- same-cycle drain and load on slot 0 ----
        force_en  = 1'b1;
        force_sel = 1'b0;
        out_ready = 2'b01;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        tick();
        chk("dl_valid_a", {30'd0, out_valid}, 32'd1);
        chk("dl_data0_a", {24'd0, out_data0}, 32'h5A);
        in_data = 8'hA5;
        #1;
        chk("dl_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("dl_valid_b", {30'd0, out_valid}, 32'd1);
        chk("dl_data0_b", {24'd0, out_data0}, 32'hA5);
        chk("dl_cnt0", {28'd0, cnt0}, 32'd5);
        in_valid = 1'b0;
        tick();
        chk("dl_drained", {30'd0, out_valid}, 32'd0);

        // ---- asynchronous reset with both slots full ----
        force_en  = 1'b0;
        out_ready = 2'b00;
        in_valid  = 1'b1;
        in_data   = 8'hC0;
        tick();
        in_data = 8'hC1;
        tick();
        in_valid = 1'b0;
        chk("ar_full", {30'd0, out_valid}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {30'd0, out_valid}, 32'd0);
        chk("ar_cnt0", {28'd0, cnt0}, 32'd0);
        chk("ar_cnt1", {28'd0, cnt1}, 32'd0);
        chk("ar_sel", {31'd0, sel_o}, 32'd0);
        chk("ar_data0", {24'd0, out_data0}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- counter wrap on channel 0 (CW=4) ----
        force_en  = 1'b1;
        force_sel = 1'b0;
        out_ready = 2'b01;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i);
            tick();
        end
        chk("wrap_cnt0_16", {28'd0, cnt0}, 32'd0);
        in_data = 8'h10;
        tick();
        chk("wrap_cnt0_17", {28'd0, cnt0}, 32'd1);
        chk("wrap_cnt1", {28'd0, cnt1}, 32'd0);
        chk("wrap_data0", {24'd0, out_data0}, 32'h10);
        in_valid = 1'b0;
        tick();

        // ---- round-robin with slot 0 blocked, slot 1 empty ----
        out_ready = 2'b00;
        in_valid  = 1'b1;
        in_data   = 8'hD0;
        tick();
        chk("sk_valid_a", {30'd0, out_valid}, 32'd1);
        force_en = 1'b0;
        in_data  = 8'hD1;
        #1;
`ifdef DEMUX_DISPATCH_SKIP_EN
        chk("sk_sel", {31'd0, sel_o}, 32'd1);
        chk("sk_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sk_valid_b", {30'd0, out_valid}, 32'd3);
        chk("sk_data1", {24'd0, out_data1}, 32'hD1);
        chk("sk_cnt1", {28'd0, cnt1}, 32'd1);
        chk("sk_next_sel", {31'd0, sel_o}, 32'd0);
`else
        chk("st_sel", {31'd0, sel_o}, 32'd0);
        chk("st_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("st_valid_b", {30'd0, out_valid}, 32'd1);
        chk("st_cnt1", {28'd0, cnt1}, 32'd0);
        chk("st_data0", {24'd0, out_data0}, 32'hD0);
`endif
        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demux_1x2_dispatch

// File: doc/demux_1x2_dispatch.md
Name: demux_1x2_dispatch

Overview:
Registered front-end that feeds the 1x2 demux stage. It accepts a valid/ready input stream and steers each word to one of two output slots. Steering is either strict round-robin or a forced select with enable, matching the demux f/en/s semantics. Each output slot holds one word until its consumer takes it. Per-channel dispatch counters support debug and bring-up.

Parameters:
DW, 8, data word width in bits
CW, 16, width of each per-channel dispatch counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  block can accept the input word this cycle
in_data  input  DW  input word
force_en  input  1  1 = route to force_sel; 0 = round-robin
force_sel  input  1  forced target channel (the demux s)
out_valid  output  2  bit i = slot i holds a word
out_ready  input  2  bit i = consumer i takes the word this cycle
out_data0  output  DW  slot 0 word
out_data1  output  DW  slot 1 word
sel_o  output  1  channel the next accepted word will go to
cnt0  output  CW  words dispatched to channel 0
cnt1  output  CW  words dispatched to channel 1

Behaviour:
- Reset (async assert, sync release):
  - out_valid=2'b00, out_data0/1=0.
  - Round-robin pointer ptr=0.
  - cnt0=cnt1=0.
- Target channel: tgt = force_en ? force_sel : ptr. sel_o = tgt, combinational.
- Slot i can load when: !out_valid[i] || out_ready[i].
- in_ready = "slot tgt can load". Combinational; no dependency on in_valid.
- Accept event = in_valid && in_ready.
- On an accept:
  - slot tgt loads in_data and sets its valid bit.
  - cnt[tgt] increments, wrapping at 2^CW.
  - ptr toggles only when force_en=0. A forced accept leaves ptr unchanged.
- Drain on slot i (out_valid[i] && out_ready[i]) with no load into slot i: out_valid[i] clears.
  - out_data[i] holds its last value; data is don't-care when valid=0.
- Drain and load on the same slot in the same cycle: slot takes the new word and out_valid[i] stays 1. Full throughput, no bubble.
- Latency: a word accepted at edge N appears on out_data[tgt] with out_valid after edge N. One-cycle latency.
- Strict round-robin, no skip: if slot ptr is full and not draining, in_ready=0 even when the other slot is empty.
- Changes to force_en/force_sel never alter words already held in the slots.
- Both slots are independent. Both may be valid at once, and both may drain in the same cycle.
- out_ready on an empty slot is ignored.
- Reset asserted mid-transfer: held words are discarded immediately. No partial state survives.

Optional Feature:
Macro: DEMUX_DISPATCH_SKIP_EN
- Defined: in round-robin mode (force_en=0), if slot ptr cannot load but the other slot can, tgt = ~ptr.
  - sel_o reflects this skip target.
  - After the accept, ptr = ~tgt, so the next word goes to the channel that was skipped.
  - Forced mode is unaffected.
- Not defined: strict alternation as above. No skip logic is synthesized.

Decomposition:
- Package demux_pkg holds:
  - DW_DEFAULT=8, CW_DEFAULT=16.
  - Channel index constants CH0=1'b0, CH1=1'b1.
- Sub-module demux_out_slot: one-entry holding register with valid/ready and a can_load output. Instantiated twice.
- Top level holds ptr, target select, the counters and in_ready.

Test Plan:
- Reset: assert rst_n=0 mid-stream while out_valid=2'b11 -> out_valid=0, cnt0=cnt1=0, sel_o=0 immediately, before any clock edge.
- Round-robin with out_ready=2'b11, in_valid held 1, data 0x11,0x22,0x33,0x44 -> out_data0 gets 0x11 then 0x33; out_data1 gets 0x22 then 0x44; in_ready stays 1; cnt0=2, cnt1=2.
- Backpressure, skip off: out_ready=2'b00, send 0xA0 then 0xA1 -> both slots full, in_ready=0. Release out_ready[1] only -> in_ready stays 0, since ptr=0 and slot 0 is still full.
- Forced routing: force_en=1, force_sel=1, out_ready=2'b10, send 4 words -> all 4 appear on out_data1, cnt1=4, cnt0=0. On return to force_en=0, ptr is unchanged and still 0.
- Same-cycle drain and load on slot 0 (force_en=1, force_sel=0, out_ready[0]=1, back-to-back 0x5A,0xA5) -> out_valid[0] stays 1 across both words; out_data0 shows 0x5A then 0xA5.
- Counter wrap (CW=4): dispatch 17 words to channel 0 -> cnt0=1. With DEMUX_DISPATCH_SKIP_EN defined: slot 0 full, slot 1 empty, force_en=0 -> word routes to slot 1 and the next sel_o=0.
